// File: rtl/inst_seq_pkg.sv
// Shared types and helpers for the HDC instruction sequencer.
// Imported by inst_seq_control and inst_loop_nest.
package inst_seq_pkg;

    localparam int unsigned MaxNumLoops = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Requests for more loops than the hardware provides fall back to the full nest.
    function automatic int unsigned sat_loop_num(input int unsigned req,
                                                 input int unsigned num_loops);
        return (req > num_loops) ? num_loops : req;
    endfunction

endpackage

// File: rtl/inst_loop_nest.sv
// Nested hardware loop engine: per-loop iteration counters and the
// priority select that decides whether the current PC jumps back.
module inst_loop_nest
    import inst_seq_pkg::*;
#(
    parameter int unsigned NumLoops       = 4,
    parameter int unsigned AddrWidth      = 7,
    parameter int unsigned LoopCountWidth = 16,
    parameter int unsigned LoopSelWidth   = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clr_i,
    input  logic                               step_i,
    input  logic                               cnt_rst_i,
    input  logic [AddrWidth-1:0]               pc_i,
    input  logic [LoopSelWidth-1:0]            loop_num_i,
    input  logic [NumLoops*AddrWidth-1:0]      loop_jump_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]      loop_end_addr_i,
    input  logic [NumLoops*LoopCountWidth-1:0] loop_count_i,
    output logic                               jump_o,
    output logic [AddrWidth-1:0]               jump_addr_o,
    output logic                               no_jump_o
);

    logic [LoopCountWidth-1:0] cnt_q [NumLoops];
    logic [NumLoops-1:0]       match;
    logic [NumLoops-1:0]       qualify;
    logic [NumLoops-1:0]       inc_vec;
    logic [NumLoops-1:0]       rst_vec;
    logic [LoopCountWidth-1:0] cnt_lim [NumLoops];

    // A loop qualifies while it still has iterations left; a count of 0 behaves like 1.
    always_comb begin
        for (int k = 0; k < int'(NumLoops); k++) begin
            match[k]   = (k < int'(loop_num_i)) &&
                         (pc_i == loop_end_addr_i[k*AddrWidth +: AddrWidth]);
            cnt_lim[k] = (loop_count_i[k*LoopCountWidth +: LoopCountWidth] == '0) ? '0 :
                         loop_count_i[k*LoopCountWidth +: LoopCountWidth] - LoopCountWidth'(1);
            qualify[k] = match[k] && (cnt_q[k] < cnt_lim[k]);
        end
    end

    always_comb begin
        int sel;
        logic jump_d;
        sel         = 0;
        jump_d      = 1'b0;
        jump_addr_o = '0;
        inc_vec     = '0;
        rst_vec     = '0;
        for (int k = 0; k < int'(NumLoops); k++) begin
            if (qualify[k]) begin
                sel         = k;
                jump_d      = 1'b1;
                jump_addr_o = loop_jump_addr_i[k*AddrWidth +: AddrWidth];
            end
        end
        if (jump_d) begin
            inc_vec[sel] = 1'b1;
        end
        // Inner loops sharing the end address restart when an outer one jumps back.
        for (int k = 0; k < int'(NumLoops); k++) begin
            if (match[k] && (!jump_d || k > sel)) begin
                rst_vec[k] = 1'b1;
            end
        end
        jump_o    = jump_d;
        no_jump_o = !jump_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(NumLoops); k++) begin
                cnt_q[k] <= '0;
            end
        end else if (clr_i || cnt_rst_i) begin
            for (int k = 0; k < int'(NumLoops); k++) begin
                cnt_q[k] <= '0;
            end
        end else if (step_i) begin
            for (int k = 0; k < int'(NumLoops); k++) begin
                if (inc_vec[k]) begin
                    cnt_q[k] <= cnt_q[k] + LoopCountWidth'(1);
                end else if (rst_vec[k]) begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_1w1r.sv
// One-write/one-read register file with combinational read and synchronous clear.
// Contents are deliberately not touched by the asynchronous reset.
module reg_file_1w1r #(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned Depth     = 128,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_seq_control.sv
// HDC instruction sequencer: instruction memory, PC, program load and nested loops.
// Optional macro INST_SEQ_DBG_EN enables the debug read-address override.
module inst_seq_control
    import inst_seq_pkg::*;
#(
    parameter  int unsigned DataWidth      = 32,
    parameter  int unsigned InstMemDepth   = 128,
    parameter  int unsigned NumLoops       = 4,
    parameter  int unsigned LoopCountWidth = 16,
    localparam int unsigned AddrWidth      = $clog2(InstMemDepth),
    localparam int unsigned LoopSelWidth   = $clog2(NumLoops + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               clr_i,
    input  logic                               start_i,
    input  logic                               stall_i,
    output logic                               busy_o,
    output logic                               done_o,
    input  logic                               prog_wr_mode_i,
    input  logic [AddrWidth-1:0]               prog_wr_addr_i,
    input  logic                               prog_wr_addr_en_i,
    input  logic [DataWidth-1:0]               prog_wr_data_i,
    input  logic                               prog_wr_data_en_i,
    input  logic [AddrWidth-1:0]               prog_end_addr_i,
    input  logic [LoopSelWidth-1:0]            loop_num_i,
    input  logic [NumLoops*AddrWidth-1:0]      loop_jump_addr_i,
    input  logic [NumLoops*AddrWidth-1:0]      loop_end_addr_i,
    input  logic [NumLoops*LoopCountWidth-1:0] loop_count_i,
    output logic [AddrWidth-1:0]               inst_pc_o,
    output logic [DataWidth-1:0]               inst_rd_o,
    input  logic                               dbg_en_i,
    input  logic [AddrWidth-1:0]               dbg_addr_i
);

    localparam logic [0:0] StIdle = IDLE;
    localparam logic [0:0] StRun  = RUN;

    if (NumLoops < 1 || NumLoops > MaxNumLoops) begin : g_bad_num_loops
        $error("inst_seq_control: NumLoops out of range");
    end
    if (InstMemDepth < 2 || (InstMemDepth & (InstMemDepth - 1)) != 0) begin : g_bad_depth
        $error("inst_seq_control: InstMemDepth must be a power of two >= 2");
    end

    logic [0:0]              state_q;
    logic [AddrWidth-1:0]    pc_q;
    logic                    done_q;
    logic [AddrWidth-1:0]    rd_addr;
    logic                    dbg_hold;
    logic                    step;
    logic                    complete;
    logic                    jump;
    logic                    no_jump;
    logic [AddrWidth-1:0]    jump_addr;
    logic [LoopSelWidth-1:0] loop_num_sat;
    logic                    mem_we;

`ifdef INST_SEQ_DBG_EN
    assign dbg_hold = dbg_en_i;
    assign rd_addr  = dbg_en_i ? dbg_addr_i : pc_q;
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_en_i, dbg_addr_i};
    assign dbg_hold   = 1'b0;
    assign rd_addr    = pc_q;
`endif

    assign loop_num_sat = LoopSelWidth'(sat_loop_num(32'(loop_num_i), NumLoops));
    assign step         = (state_q == StRun) && !stall_i && !prog_wr_mode_i && !dbg_hold;
    assign complete     = step && no_jump && (pc_q == prog_end_addr_i);
    assign mem_we       = prog_wr_mode_i && prog_wr_data_en_i && !prog_wr_addr_en_i;

    inst_loop_nest #(
        .NumLoops      (NumLoops),
        .AddrWidth     (AddrWidth),
        .LoopCountWidth(LoopCountWidth),
        .LoopSelWidth  (LoopSelWidth)
    ) u_loop_nest (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clr_i           (clr_i),
        .step_i          (step),
        .cnt_rst_i       (complete),
        .pc_i            (pc_q),
        .loop_num_i      (loop_num_sat),
        .loop_jump_addr_i(loop_jump_addr_i),
        .loop_end_addr_i (loop_end_addr_i),
        .loop_count_i    (loop_count_i),
        .jump_o          (jump),
        .jump_addr_o     (jump_addr),
        .no_jump_o       (no_jump)
    );

    reg_file_1w1r #(
        .DataWidth(DataWidth),
        .Depth    (InstMemDepth)
    ) u_inst_mem (
        .clk_i  (clk_i),
        .clr_i  (clr_i),
        .we_i   (mem_we),
        .waddr_i(pc_q),
        .wdata_i(prog_wr_data_i),
        .raddr_i(rd_addr),
        .rdata_o(inst_rd_o)
    );

    // Program-load mode owns the PC and holds the FSM; otherwise the FSM walks the program.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= StIdle;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else if (prog_wr_mode_i) begin
            done_q <= 1'b0;
            if (prog_wr_addr_en_i) begin
                pc_q <= prog_wr_addr_i;
            end else if (prog_wr_data_en_i) begin
                pc_q <= pc_q + AddrWidth'(1);
            end
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (start_i) begin
                    state_q <= StRun;
                end
            end else if (step) begin
                if (jump) begin
                    pc_q <= jump_addr;
                end else if (complete) begin
                    state_q <= StIdle;
                    pc_q    <= '0;
                    done_q  <= 1'b1;
                end else begin
                    pc_q <= pc_q + AddrWidth'(1);
                end
            end
        end
    end

    assign busy_o    = (state_q == StRun);
    assign done_o    = done_q;
    assign inst_pc_o = pc_q;

endmodule

// File: tb/tb_inst_seq_control.sv
// Scoreboard bench for inst_seq_control: expected PC/instruction streams are
// queued when a run is launched and compared cycle by cycle.
module tb_inst_seq_control;

    localparam int DW = 32;
    localparam int DEPTH = 128;
    localparam int NL = 4;
    localparam int CW = 16;
    localparam int AW = 7;
    localparam int SW = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clr_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stall_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic             prog_wr_mode_i = 1'b0;
    logic [AW-1:0]    prog_wr_addr_i = '0;
    logic             prog_wr_addr_en_i = 1'b0;
    logic [DW-1:0]    prog_wr_data_i = '0;
    logic             prog_wr_data_en_i = 1'b0;
    logic [AW-1:0]    prog_end_addr_i = '0;
    logic [SW-1:0]    loop_num_i = '0;
    logic [NL*AW-1:0] loop_jump_addr_i = '0;
    logic [NL*AW-1:0] loop_end_addr_i = '0;
    logic [NL*CW-1:0] loop_count_i = '0;
    logic [AW-1:0]    inst_pc_o;
    logic [DW-1:0]    inst_rd_o;
    logic             dbg_en_i = 1'b0;
    logic [AW-1:0]    dbg_addr_i = '0;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] mem_model [DEPTH];
    int unsigned exp_pc_q [$];
    int unsigned seq [$];

    always #5 clk_i = ~clk_i;

    inst_seq_control dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clr_i            (clr_i),
        .start_i          (start_i),
        .stall_i          (stall_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .prog_wr_mode_i   (prog_wr_mode_i),
        .prog_wr_addr_i   (prog_wr_addr_i),
        .prog_wr_addr_en_i(prog_wr_addr_en_i),
        .prog_wr_data_i   (prog_wr_data_i),
        .prog_wr_data_en_i(prog_wr_data_en_i),
        .prog_end_addr_i  (prog_end_addr_i),
        .loop_num_i       (loop_num_i),
        .loop_jump_addr_i (loop_jump_addr_i),
        .loop_end_addr_i  (loop_end_addr_i),
        .loop_count_i     (loop_count_i),
        .inst_pc_o        (inst_pc_o),
        .inst_rd_o        (inst_rd_o),
        .dbg_en_i         (dbg_en_i),
        .dbg_addr_i       (dbg_addr_i)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setLoop(input int k, input int j, input int e, input int c);
        loop_jump_addr_i[k*AW +: AW] = AW'(j);
        loop_end_addr_i[k*AW +: AW]  = AW'(e);
        loop_count_i[k*CW +: CW]     = CW'(c);
    endtask

    // Expected PC stream: each stalled cycle repeats the PC seen when the stall was raised.
    task automatic pushSeq(input int stall_at, input int stall_len);
        for (int i = 0; i < seq.size(); i++) begin
            exp_pc_q.push_back(seq[i]);
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) exp_pc_q.push_back(seq[i]);
            end
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic runProgram(input string tag, input int stall_at, input int stall_len);
        int c;
        int unsigned e;
        c = 0;
        applyStimulus();
        while (exp_pc_q.size() > 0) begin
            e = exp_pc_q.pop_front();
            checkOutput({tag, " pc"}, 64'(inst_pc_o), 64'(e));
            checkOutput({tag, " rd"}, 64'(inst_rd_o), 64'(mem_model[e]));
            checkOutput({tag, " busy"}, 64'(busy_o), 64'd1);
            stall_i = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
            c++;
            @(negedge clk_i);
        end
        stall_i = 1'b0;
        checkOutput({tag, " done"}, 64'(done_o), 64'd1);
        checkOutput({tag, " busy end"}, 64'(busy_o), 64'd0);
        checkOutput({tag, " pc end"}, 64'(inst_pc_o), 64'd0);
        @(negedge clk_i);
        checkOutput({tag, " done once"}, 64'(done_o), 64'd0);
    endtask

    task automatic loadWord(input logic [DW-1:0] w, input int addr);
        prog_wr_data_i    = w;
        prog_wr_data_en_i = 1'b1;
        @(negedge clk_i);
        prog_wr_data_en_i = 1'b0;
        mem_model[addr]   = w;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;

        // Reset state
        @(negedge clk_i);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset done", 64'(done_o), 64'd0);
        checkOutput("reset pc", 64'(inst_pc_o), 64'd0);
        rst_ni = 1'b1;
        clr_i  = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        checkOutput("clr rd", 64'(inst_rd_o), 64'd0);

        // Program load: 8 words from address 0, then addr_en beats data_en
        prog_wr_mode_i    = 1'b1;
        prog_wr_addr_i    = '0;
        prog_wr_addr_en_i = 1'b1;
        @(negedge clk_i);
        prog_wr_addr_en_i = 1'b0;
        for (int i = 0; i < 8; i++) loadWord($urandom | 32'h1, i);
        checkOutput("load pc", 64'(inst_pc_o), 64'd8);
        prog_wr_addr_en_i = 1'b1;
        prog_wr_data_en_i = 1'b1;
        prog_wr_data_i    = 32'hDEADBEEF;
        start_i           = 1'b1;
        @(negedge clk_i);
        prog_wr_addr_en_i = 1'b0;
        prog_wr_data_en_i = 1'b0;
        start_i           = 1'b0;
        checkOutput("addr_en prio pc", 64'(inst_pc_o), 64'd0);
        checkOutput("addr_en prio rd", 64'(inst_rd_o), 64'(mem_model[0]));
        checkOutput("start in load", 64'(busy_o), 64'd0);
        prog_wr_mode_i = 1'b0;

        // Straight-line program
        prog_end_addr_i = AW'(3);
        loop_num_i      = '0;
        seq = '{0, 1, 2, 3};
        pushSeq(-1, 0);
        runProgram("linear", 0, 0);

        // Single loop
        loop_num_i = SW'(1);
        setLoop(0, 1, 2, 3);
        seq = '{0, 1, 2, 1, 2, 1, 2, 3};
        pushSeq(-1, 0);
        runProgram("single", 0, 0);

        // Same loop with a 3-cycle stall inside the second iteration
        pushSeq(3, 3);
        runProgram("stall", 3, 3);

        // Shared end address; loop_num above NumLoops saturates, loops 2/3 never hit
        loop_num_i = SW'(7);
        setLoop(0, 0, 2, 2);
        setLoop(1, 1, 2, 2);
        setLoop(2, 5, 10, 4);
        setLoop(3, 5, 11, 4);
        seq = '{0, 1, 2, 1, 2, 0, 1, 2, 1, 2, 3};
        pushSeq(-1, 0);
        runProgram("shared", 0, 0);

        // Count of zero runs the body once
        loop_num_i = SW'(1);
        setLoop(0, 1, 2, 0);
        seq = '{0, 1, 2, 3};
        pushSeq(-1, 0);
        runProgram("count0", 0, 0);

        // Debug read override
        loop_num_i = '0;
        applyStimulus();
        dbg_en_i   = 1'b1;
        dbg_addr_i = AW'(5);
        @(negedge clk_i);
`ifdef INST_SEQ_DBG_EN
        checkOutput("dbg pc hold", 64'(inst_pc_o), 64'd0);
        checkOutput("dbg rd", 64'(inst_rd_o), 64'(mem_model[5]));
`else
        checkOutput("dbg ignored pc", 64'(inst_pc_o), 64'd1);
        checkOutput("dbg ignored rd", 64'(inst_rd_o), 64'(mem_model[1]));
`endif
        dbg_en_i = 1'b0;
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("dbg done", 64'(done_o), 64'd1);

        // Asynchronous reset mid-run keeps memory contents
        loop_num_i = SW'(1);
        setLoop(0, 1, 2, 3);
        applyStimulus();
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("areset busy", 64'(busy_o), 64'd0);
        checkOutput("areset pc", 64'(inst_pc_o), 64'd0);
        checkOutput("areset mem kept", 64'(inst_rd_o), 64'(mem_model[0]));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Clear together with start mid-run
        applyStimulus();
        repeat (2) @(negedge clk_i);
        clr_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        clr_i   = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        checkOutput("clr busy", 64'(busy_o), 64'd0);
        checkOutput("clr pc", 64'(inst_pc_o), 64'd0);
        checkOutput("clr rd mem", 64'(inst_rd_o), 64'(mem_model[0]));
        checkOutput("clr done", 64'(done_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
